// File: rtl/register_bank_pkg.sv
// Shared sizing constants and helpers for the RV32 integer register bank and its scoreboard.
package register_bank_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam int SB_W = 2;

  localparam logic [AW-1:0]   REG_ZERO = '0;
  localparam logic [SB_W-1:0] SB_MAX   = '1;

  // Outstanding writes left once a same-cycle writeback retires one; an untracked
  // writeback (count already zero) must not wrap the count and cause a false stall.
  function automatic logic pend_nonzero(input logic [SB_W-1:0] cnt, input logic hit);
    logic [SB_W-1:0] eff;
    eff = cnt - SB_W'(hit && (cnt != '0));
    return eff != '0;
  endfunction

endpackage

// File: rtl/register_bank_if.sv
// Decode/writeback-facing signal bundle of the register bank.
interface register_bank_if;
  import register_bank_pkg::*;

  logic            wb_w_en;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_used;
  logic            rs2_used;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            issue_valid;
  logic            issue_we;
  logic [AW-1:0]   issue_rd;
  logic            stall;
  logic            sb_overflow;

  modport master (
    output wb_w_en, wb_rd, wb_data, rs1, rs2, rs1_used, rs2_used,
           issue_valid, issue_we, issue_rd,
    input  rs1_data, rs2_data, stall, sb_overflow
  );

  modport slave (
    input  wb_w_en, wb_rd, wb_data, rs1, rs2, rs1_used, rs2_used,
           issue_valid, issue_we, issue_rd,
    output rs1_data, rs2_data, stall, sb_overflow
  );

endinterface

// File: rtl/register_bank_scoreboard.sv
// Per-register in-flight write counters: set at issue, cleared at writeback; produce the
// decode stall for RAW hazards and counter saturation, plus a sticky overflow flag.
module reg_scoreboard
  import register_bank_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_w_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          rs1_used,
  input  logic          rs2_used,
  input  logic          issue_valid,
  input  logic          issue_we,
  input  logic [AW-1:0] issue_rd,
  output logic          stall,
  output logic          sb_overflow
);

  logic [SB_W-1:0] cnt [NREG];
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;
  logic            hit_rs1;
  logic            hit_rs2;
  logic            hit_issue;
  logic            raw_stall;
  logic            sat_stall;
  logic            accept;

  always_comb begin
    hit_rs1   = wb_w_en && (wb_rd == rs1) && (rs1 != REG_ZERO);
    hit_rs2   = wb_w_en && (wb_rd == rs2) && (rs2 != REG_ZERO);
    hit_issue = wb_w_en && (wb_rd == issue_rd) && (issue_rd != REG_ZERO);

    raw_stall = (rs1_used && (rs1 != REG_ZERO) && pend_nonzero(cnt[rs1], hit_rs1)) ||
                (rs2_used && (rs2 != REG_ZERO) && pend_nonzero(cnt[rs2], hit_rs2));
    // A writeback retiring on the saturated register frees a slot this same cycle.
    sat_stall = issue_valid && issue_we && (issue_rd != REG_ZERO) &&
                (cnt[issue_rd] == SB_MAX) && !hit_issue;

    stall  = raw_stall || sat_stall;
    accept = issue_valid && !stall;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_vec[r] = accept && issue_we && (issue_rd == AW'(r));
      dec_vec[r] = wb_w_en && (wb_rd == AW'(r)) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_overflow <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])      cnt[r] <= cnt[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= cnt[r] - 1'b1;
      end
      if (sat_stall && !raw_stall) sb_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/register_bank.sv
// RV32 integer register file: two combinational read ports with writeback bypass,
// one write port, x0 hardwired to zero; hazard tracking lives in reg_scoreboard.
module register_bank
  import register_bank_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  register_bank_if.slave bus
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (bus.wb_w_en && (bus.wb_rd != REG_ZERO)) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Same-cycle writeback data wins over the stored value so decode sees it without a bubble.
  always_comb begin
    if (bus.rs1 == REG_ZERO)                          bus.rs1_data = '0;
    else if (bus.wb_w_en && (bus.wb_rd == bus.rs1))   bus.rs1_data = bus.wb_data;
    else                                              bus.rs1_data = regs[bus.rs1];

    if (bus.rs2 == REG_ZERO)                          bus.rs2_data = '0;
    else if (bus.wb_w_en && (bus.wb_rd == bus.rs2))   bus.rs2_data = bus.wb_data;
    else                                              bus.rs2_data = regs[bus.rs2];
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_w_en     (bus.wb_w_en),
    .wb_rd       (bus.wb_rd),
    .rs1         (bus.rs1),
    .rs2         (bus.rs2),
    .rs1_used    (bus.rs1_used),
    .rs2_used    (bus.rs2_used),
    .issue_valid (bus.issue_valid),
    .issue_we    (bus.issue_we),
    .issue_rd    (bus.issue_rd),
    .stall       (bus.stall),
    .sb_overflow (bus.sb_overflow)
  );

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: reset, x0, bypass, RAW stall,
// simultaneous issue/writeback and scoreboard saturation.
module tb_register_bank;
  import register_bank_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  register_bank_if bus ();

  register_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(
    input logic            wb_w_en,
    input logic [AW-1:0]   wb_rd,
    input logic [XLEN-1:0] wb_data,
    input logic [AW-1:0]   rs1,
    input logic            rs1_used,
    input logic [AW-1:0]   rs2,
    input logic            rs2_used,
    input logic            issue_valid,
    input logic [AW-1:0]   issue_rd
  );
    bus.wb_w_en     = wb_w_en;
    bus.wb_rd       = wb_rd;
    bus.wb_data     = wb_data;
    bus.rs1         = rs1;
    bus.rs1_used    = rs1_used;
    bus.rs2         = rs2;
    bus.rs2_used    = rs2_used;
    bus.issue_valid = issue_valid;
    bus.issue_we    = issue_valid;
    bus.issue_rd    = issue_rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(0, 0, 0, 5, 1, 6, 1, 0, 0);
    checkOutput("reset_rs1_data", bus.rs1_data, 32'h0);
    checkOutput("reset_stall", {31'b0, bus.stall}, 32'h0);
    checkOutput("reset_overflow", {31'b0, bus.sb_overflow}, 32'h0);
    #10 rst_n = 1'b1;
    nextCycle();

    // Write x5 and issue x6, then reset asynchronously mid-cycle.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 6);
    checkOutput("issue_x6_accept", {31'b0, bus.stall}, 32'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 5, 1, 6, 1, 0, 0);
    checkOutput("x5_written", bus.rs1_data, 32'hDEADBEEF);
    checkOutput("x6_pending_stall", {31'b0, bus.stall}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_rs1", bus.rs1_data, 32'h0);
    checkOutput("async_reset_stall", {31'b0, bus.stall}, 32'h0);
    #2 rst_n = 1'b1;
    nextCycle();
    applyStimulus(0, 0, 0, 5, 1, 6, 1, 0, 0);
    checkOutput("post_reset_x5", bus.rs1_data, 32'h0);
    checkOutput("post_reset_no_stall", {31'b0, bus.stall}, 32'h0);

    // x0 write ignored, x0 issue never tracked.
    applyStimulus(1, 0, 32'hFFFFFFFF, 0, 1, 0, 1, 0, 0);
    checkOutput("x0_no_bypass", bus.rs1_data, 32'h0);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 1, 0);
      checkOutput("x0_issue_no_stall", {31'b0, bus.stall}, 32'h0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0);
    checkOutput("x0_reads_zero", bus.rs1_data, 32'h0);
    checkOutput("x0_read_no_stall", {31'b0, bus.stall}, 32'h0);

    // Bypass on x7.
    applyStimulus(1, 7, 32'h11, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 7, 0, 7, 0, 0, 0);
    checkOutput("x7_old_value", bus.rs1_data, 32'h11);
    applyStimulus(1, 7, 32'h22, 7, 0, 7, 0, 0, 0);
    checkOutput("x7_bypass_rs2", bus.rs2_data, 32'h22);
    checkOutput("x7_bypass_rs1", bus.rs1_data, 32'h22);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 7, 0, 0, 0);
    checkOutput("x7_stored", bus.rs2_data, 32'h22);

    // RAW stall on x3, released by the same-cycle writeback.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3);
    checkOutput("issue_x3_accept", {31'b0, bus.stall}, 32'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 3, 1, 0, 0, 0, 0);
    checkOutput("raw_x3_stall", {31'b0, bus.stall}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 3, 1, 0, 0);
    checkOutput("raw_x3_stall_rs2", {31'b0, bus.stall}, 32'h1);
    nextCycle();
    applyStimulus(1, 3, 32'hABCD, 3, 1, 0, 0, 0, 0);
    checkOutput("raw_x3_wb_release", {31'b0, bus.stall}, 32'h0);
    checkOutput("raw_x3_bypass", bus.rs1_data, 32'hABCD);
    nextCycle();
    applyStimulus(0, 0, 0, 3, 1, 0, 0, 0, 0);
    checkOutput("x3_cleared", {31'b0, bus.stall}, 32'h0);
    checkOutput("x3_value", bus.rs1_data, 32'hABCD);
    checkOutput("no_overflow_yet", {31'b0, bus.sb_overflow}, 32'h0);

    // Simultaneous issue and writeback on x9 keeps the count at 1.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
    nextCycle();
    applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 1, 9);
    checkOutput("x9_issue_wb_accept", {31'b0, bus.stall}, 32'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 9, 1, 0, 0, 0, 0);
    checkOutput("x9_still_pending", {31'b0, bus.stall}, 32'h1);
    applyStimulus(0, 0, 0, 9, 0, 0, 0, 0, 0);
    checkOutput("x9_unused_no_stall", {31'b0, bus.stall}, 32'h0);
    checkOutput("x9_value", bus.rs1_data, 32'h99);
    applyStimulus(1, 9, 32'h98, 0, 0, 0, 0, 0, 0);
    nextCycle();

    // Saturate x4.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);
      checkOutput("x4_issue_accept", {31'b0, bus.stall}, 32'h0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);
    checkOutput("x4_saturated_stall", {31'b0, bus.stall}, 32'h1);
    checkOutput("x4_overflow_not_yet", {31'b0, bus.sb_overflow}, 32'h0);
    nextCycle();
    checkOutput("x4_overflow_set", {31'b0, bus.sb_overflow}, 32'h1);
    applyStimulus(1, 4, 32'h44, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);
    checkOutput("x4_issue_after_wb", {31'b0, bus.stall}, 32'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);
    checkOutput("x4_full_again", {31'b0, bus.stall}, 32'h1);
    checkOutput("overflow_sticky", {31'b0, bus.sb_overflow}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 4, 1, 0, 0);
    checkOutput("x4_raw_stall", {31'b0, bus.stall}, 32'h1);
    checkOutput("x4_value", bus.rs2_data, 32'h44);

    // Reset clears the sticky flag and all pending writes.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_clears_overflow", {31'b0, bus.sb_overflow}, 32'h0);
    checkOutput("reset_clears_x4_stall", {31'b0, bus.stall}, 32'h0);
    #2 rst_n = 1'b1;
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
